// File: rtl/matmul_tt_sequencer_if.sv
// Operand-read bus and result stream between the transposed-operand matmul
// sequencer and its operand memories / result consumer.
interface matmul_tt_sequencer_if;
  logic        rd_en;
  logic [15:0] a_addr;
  logic [15:0] b_addr;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        c_valid;
  logic        c_ready;
  logic [31:0] c_data;
  logic [15:0] c_addr;

  modport master (
    output rd_en,
    output a_addr,
    output b_addr,
    input  a_data,
    input  b_data,
    output c_valid,
    input  c_ready,
    output c_data,
    output c_addr
  );

  modport slave (
    input  rd_en,
    input  a_addr,
    input  b_addr,
    output a_data,
    output b_data,
    input  c_valid,
    output c_ready,
    input  c_data,
    input  c_addr
  );
endinterface

// File: rtl/matmul_tt_sequencer.sv
// Sequencer computing C = A^T * B^T one element at a time: for each (i,j) it
// streams k operand reads, accumulates the products one cycle behind the reads,
// then offers the finished element on a valid/ready stream.
module matmul_tt_sequencer (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [7:0]                   cfg_m,
  input  logic [7:0]                   cfg_n,
  input  logic [7:0]                   cfg_k,
  matmul_tt_sequencer_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0] m_q;
  logic [7:0] n_q;
  logic [7:0] k_q;
  logic [7:0] i_q;
  logic [7:0] j_q;
  logic [7:0] kc_q;

  logic zero_dim;
  logic start_ok;
  logic start_bad;
  logic last_k;
  logic last_elem;

  logic rd_en;
  logic c_valid;
  logic done_fsm;

  logic rd_q;
  logic first_q;
  logic zero_q;

  logic signed [31:0] a_ext;
  logic signed [31:0] b_ext;
  logic signed [31:0] product;
  logic signed [31:0] acc_q;

  assign zero_dim  = (cfg_m == 8'd0) || (cfg_n == 8'd0) || (cfg_k == 8'd0);
  assign start_ok  = start && (state_q == ST_IDLE) && !zero_dim;
  assign start_bad = start && (state_q == ST_IDLE) && zero_dim;
  assign last_k    = (kc_q == k_q - 8'd1);
  assign last_elem = (i_q == m_q - 8'd1) && (j_q == n_q - 8'd1);

  assign a_ext   = {{16{bus.a_data[15]}}, bus.a_data};
  assign b_ext   = {{16{bus.b_data[15]}}, bus.b_data};
  assign product = a_ext * b_ext;

  assign bus.a_addr  = ({8'd0, kc_q} * {8'd0, m_q}) + {8'd0, i_q};
  assign bus.b_addr  = ({8'd0, j_q} * {8'd0, k_q}) + {8'd0, kc_q};
  assign bus.c_addr  = ({8'd0, i_q} * {8'd0, n_q}) + {8'd0, j_q};
  assign bus.c_data  = acc_q;
  assign bus.rd_en   = rd_en;
  assign bus.c_valid = c_valid;

  assign busy = (state_q != ST_IDLE);
  assign done = done_fsm | zero_q;
  assign err  = zero_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes; abort beats everything outside IDLE.
  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    c_valid  = 1'b0;
    done_fsm = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_en = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_k) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = abort ? ST_IDLE : ST_OUT;
      end
      ST_OUT: begin
        c_valid = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bus.c_ready) begin
          state_d = last_elem ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        done_fsm = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job dimensions captured at start, plus the i/j/k loop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q  <= '0;
      n_q  <= '0;
      k_q  <= '0;
      i_q  <= '0;
      j_q  <= '0;
      kc_q <= '0;
    end else if (start_ok) begin
      m_q  <= cfg_m;
      n_q  <= cfg_n;
      k_q  <= cfg_k;
      i_q  <= '0;
      j_q  <= '0;
      kc_q <= '0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (abort || last_k) begin
            kc_q <= '0;
          end else begin
            kc_q <= kc_q + 8'd1;
          end
        end
        ST_OUT: begin
          if (!abort && bus.c_ready && !last_elem) begin
            if (j_q == n_q - 8'd1) begin
              j_q <= '0;
              i_q <= i_q + 8'd1;
            end else begin
              j_q <= j_q + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read strobe delayed by one cycle to line up with the returning operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      rd_q    <= rd_en;
      first_q <= rd_en && (kc_q == 8'd0);
    end
  end

  // Accumulator: the k=0 product restarts the sum, later products add with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (rd_q) begin
      acc_q <= first_q ? product : acc_q + product;
    end
  end

  // One-cycle err/done pulse for a start carrying a zero dimension.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= start_bad;
    end
  end

endmodule

// File: tb/tb_matmul_tt_sequencer.sv
// Scoreboard bench for matmul_tt_sequencer: directed jobs push hand-computed
// elements into a queue, a negedge monitor pops and compares on each handshake.
module tb_matmul_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] cfg_m;
  logic [7:0] cfg_n;
  logic [7:0] cfg_k;
  logic       busy;
  logic       done;
  logic       err;

  matmul_tt_sequencer_if bus ();

  matmul_tt_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .cfg_m (cfg_m),
    .cfg_n (cfg_n),
    .cfg_k (cfg_k),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rd_cnt, hs_cnt, done_cnt, err_cnt;
  int first_rd, first_cv, done_cyc, last_hs, start_cyc;
  logic [15:0] a_log[$];
  logic [15:0] b_log[$];

  logic        rd_pend = 1'b0;
  logic [15:0] pa = '0;
  logic [15:0] pb = '0;
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples the DUT mid-cycle, logs reads and scores every handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      rd_pend = bus.rd_en;
      if (bus.rd_en === 1'b1) begin
        pa = bus.a_addr;
        pb = bus.b_addr;
        rd_cnt++;
        a_log.push_back(pa);
        b_log.push_back(pb);
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.c_valid === 1'b1 && first_cv < 0) first_cv = cyc;
      if (bus.c_valid === 1'b1 && bus.c_ready === 1'b1) begin
        exp_t e;
        hs_cnt++;
        last_hs = cyc;
        checkOutput("element expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("c_addr", 64'(bus.c_addr), 64'(e.addr));
          checkOutput("c_data", 64'(bus.c_data), 64'(e.data));
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err === 1'b1) err_cnt++;
    end else begin
      rd_pend = 1'b0;
    end
  end

  // Operand memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      bus.a_data = mem_a[pa[3:0]];
      bus.b_data = mem_b[pb[3:0]];
    end
  end

  task automatic clearStats();
    rd_cnt   = 0;
    hs_cnt   = 0;
    done_cnt = 0;
    err_cnt  = 0;
    first_rd = -1;
    first_cv = -1;
    done_cyc = -1;
    last_hs  = -1;
    a_log.delete();
    b_log.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] n, input logic [7:0] k);
    @(posedge clk); #2;
    cfg_m     = m;
    cfg_n     = n;
    cfg_k     = k;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("done within budget", 64'(done_cnt != 0), 64'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic checkSingleJob();
    clearStats();
    mem_a[0] = 16'd3;
    mem_b[0] = 16'hFFFC;
    exp_q.push_back('{16'd0, 32'hFFFF_FFF4});
    applyStimulus(8'd1, 8'd1, 8'd1);
    waitDone(20);
    checkOutput("1x1 first rd latency", 64'(first_rd - start_cyc), 64'd1);
    checkOutput("1x1 c_valid latency", 64'(first_cv - start_cyc), 64'd3);
    checkOutput("1x1 done latency", 64'(done_cyc - start_cyc), 64'd4);
    checkOutput("1x1 rd count", 64'(rd_cnt), 64'd1);
    checkOutput("1x1 done count", 64'(done_cnt), 64'd1);
    if (a_log.size() >= 1) begin
      checkOutput("1x1 a_addr", 64'(a_log[0]), 64'd0);
      checkOutput("1x1 b_addr", 64'(b_log[0]), 64'd0);
    end
  endtask

  task automatic load2x2();
    mem_a[0] = 16'd1; mem_a[1] = 16'd2; mem_a[2] = 16'd3; mem_a[3] = 16'd4;
    mem_b[0] = 16'd5; mem_b[1] = 16'd6; mem_b[2] = 16'd7; mem_b[3] = 16'd8;
    exp_q.push_back('{16'd0, 32'd23});
    exp_q.push_back('{16'd1, 32'd31});
    exp_q.push_back('{16'd2, 32'd34});
    exp_q.push_back('{16'd3, 32'd46});
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_m       = 8'd0;
    cfg_n       = 8'd0;
    cfg_k       = 8'd0;
    bus.c_ready = 1'b1;
    bus.a_data  = '0;
    bus.b_data  = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    clearStats();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset ctrl", {59'd0, bus.rd_en, bus.c_valid, busy, done, err}, 64'd0);
    checkOutput("reset addr", {16'd0, bus.a_addr, bus.b_addr, bus.c_addr}, 64'd0);
    checkOutput("reset c_data", 64'(bus.c_data), 64'd0);
    rst_n = 1'b1;

    // 1x1x1: 3 * -4
    checkSingleJob();

    // 2x2x2 with c_ready held high
    clearStats();
    load2x2();
    applyStimulus(8'd2, 8'd2, 8'd2);
    waitDone(60);
    checkOutput("2x2 rd count", 64'(rd_cnt), 64'd8);
    checkOutput("2x2 handshakes", 64'(hs_cnt), 64'd4);
    checkOutput("2x2 first rd to last hs", 64'(last_hs - first_rd + 1), 64'd16);
    checkOutput("2x2 done after last hs", 64'(done_cyc - last_hs), 64'd1);
    if (a_log.size() >= 2) begin
      checkOutput("2x2 a_addr seq", {32'd0, a_log[0], a_log[1]}, {32'd0, 16'd0, 16'd2});
      checkOutput("2x2 b_addr seq", {32'd0, b_log[0], b_log[1]}, {32'd0, 16'd0, 16'd1});
    end

    // Backpressure on the first of two elements (M=1, N=2, K=1)
    clearStats();
    bus.c_ready = 1'b0;
    mem_a[0] = 16'd7;
    mem_b[0] = 16'd6;
    mem_b[1] = 16'hFFFE;
    exp_q.push_back('{16'd0, 32'd42});
    exp_q.push_back('{16'd1, 32'hFFFF_FFF2});
    applyStimulus(8'd1, 8'd2, 8'd1);
    begin
      int n = 0;
      while (bus.c_valid !== 1'b1 && n < 20) begin
        @(posedge clk); #2;
        n++;
      end
    end
    checkOutput("bp c_valid reached", 64'(bus.c_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp hold", {14'd0, bus.c_valid, bus.rd_en, bus.c_data, bus.c_addr},
                  {14'd0, 1'b1, 1'b0, 32'd42, 16'd0});
    end
    @(posedge clk); #2;
    bus.c_ready = 1'b1;
    waitDone(30);
    checkOutput("bp handshakes", 64'(hs_cnt), 64'd2);
    checkOutput("bp done count", 64'(done_cnt), 64'd1);

    // Wrap: two products of (-32768)^2 sum to 2^31
    clearStats();
    mem_a[0] = 16'h8000; mem_a[1] = 16'h8000;
    mem_b[0] = 16'h8000; mem_b[1] = 16'h8000;
    exp_q.push_back('{16'd0, 32'h8000_0000});
    applyStimulus(8'd1, 8'd1, 8'd2);
    waitDone(20);
    checkOutput("wrap rd count", 64'(rd_cnt), 64'd2);

    // Zero K: err and done pulse, no activity
    clearStats();
    applyStimulus(8'd1, 8'd1, 8'd0);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("zero err count", 64'(err_cnt), 64'd1);
    checkOutput("zero done count", 64'(done_cnt), 64'd1);
    checkOutput("zero done latency", 64'(done_cyc - start_cyc), 64'd1);
    checkOutput("zero rd count", 64'(rd_cnt), 64'd0);
    checkOutput("zero no c_valid", 64'(first_cv), 64'(-1));
    checkOutput("zero busy", 64'(busy), 64'd0);

    // Start while busy (with changed cfg) is ignored
    clearStats();
    load2x2();
    applyStimulus(8'd2, 8'd2, 8'd2);
    repeat (3) @(posedge clk);
    #2;
    cfg_m = 8'd1;
    cfg_n = 8'd1;
    cfg_k = 8'd1;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    waitDone(60);
    checkOutput("busy-start rd count", 64'(rd_cnt), 64'd8);
    checkOutput("busy-start handshakes", 64'(hs_cnt), 64'd4);
    checkOutput("busy-start done count", 64'(done_cnt), 64'd1);

    // Abort during ISSUE
    clearStats();
    applyStimulus(8'd1, 8'd1, 8'd4);
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checkOutput("abort rd count", 64'(rd_cnt), 64'd2);
    checkOutput("abort done count", 64'(done_cnt), 64'd0);
    checkOutput("abort no c_valid", 64'(first_cv), 64'(-1));
    checkOutput("abort busy", 64'(busy), 64'd0);

    // Asynchronous reset during ISSUE, then a fresh 1x1x1 job
    clearStats();
    applyStimulus(8'd1, 8'd1, 8'd4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midjob reset ctrl", {59'd0, bus.rd_en, bus.c_valid, busy, done, err}, 64'd0);
    checkOutput("midjob reset addr", {16'd0, bus.a_addr, bus.b_addr, bus.c_addr}, 64'd0);
    checkOutput("midjob reset c_data", 64'(bus.c_data), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    checkSingleJob();

    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_tt_sequencer.md
MATMUL_TT_SEQUENCER -- requirements
Module: matmul_tt_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 SHALL have: start  input  1  one-cycle request to begin a job.
REQ-003 SHALL have: abort  input  1  synchronous job cancel.
REQ-004 SHALL have: cfg_m, cfg_n, cfg_k  input  8 each  dimensions; A is K x M row-major, B is N x K row-major, C is M x N row-major.
REQ-005 SHALL have: rd_en  output  1  operand read strobe; a_addr, b_addr  output  16  operand word addresses.
REQ-006 SHALL have: a_data, b_data  input  16  signed operands, valid exactly 1 cycle after rd_en.
REQ-007 SHALL have: c_valid  output  1; c_ready  input  1; c_data  output  32  signed element; c_addr  output  16  element address.
REQ-008 SHALL have: busy  output  1; done  output  1  one-cycle pulse; err  output  1  one-cycle pulse.

Function
REQ-009 SHALL compute C = A^T * B^T, C[i][j] = sum over k of A[k][i]*B[j][k], with a_addr = k*cfg_m + i and b_addr = j*cfg_k + k.
REQ-010 SHALL latch cfg_m/cfg_n/cfg_k when start is accepted; later cfg changes do not affect the running job.
REQ-011 SHALL accept start only in IDLE; start while busy is ignored.
REQ-012 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> OUT -> (ISSUE | DONE) -> IDLE.
REQ-013 Loop order: i outermost, j middle, k innermost; c_addr = i*cfg_n + j.
REQ-014 ISSUE: rd_en=1 each cycle, k counts 0..cfg_k-1; after k=cfg_k-1, go to WAIT.
REQ-015 Accumulator (32-bit, two's-complement wrap): load the product when the returning data is for k=0; otherwise add the product.
- Product is a_data*b_data, 16x16 signed to 32-bit.
- Update occurs in the cycle after the corresponding rd_en.
REQ-016 WAIT: lasts exactly 1 cycle (last product accumulates); then go to OUT.
REQ-017 OUT: c_valid=1; c_data and c_addr are held stable until c_valid && c_ready.
REQ-018 On handshake: if (i,j) is the last element, go to DONE; else advance j (wrapping j to 0 and incrementing i) and return to ISSUE with k=0.
REQ-019 DONE: done=1 for one cycle, then IDLE.
REQ-020 busy=1 in every state except IDLE.
REQ-021 rd_en SHALL be 0 in IDLE, WAIT, OUT and DONE; c_valid SHALL be 0 outside OUT.
REQ-022 Zero dimension: start with any of cfg_m/cfg_n/cfg_k = 0 gives err=1 and done=1 in the next cycle, with no rd_en and no c_valid, and the FSM stays IDLE.
REQ-023 abort in any non-IDLE state: go to IDLE next cycle, with no done and no further rd_en/c_valid; abort has priority over the c_ready handshake.
REQ-024 Throughput with c_ready held high: an element takes cfg_k+2 cycles; first rd_en is 1 cycle after start; done follows the last handshake by 1 cycle.

Reset
REQ-025 While rst_n=0 (asynchronously), all outputs and state SHALL be cleared.
- State=IDLE; rd_en, c_valid, busy, done, err = 0.
- a_addr, b_addr, c_addr, c_data and the accumulator = 0.
REQ-026 Reset mid-job SHALL discard the job; after release the block waits for a new start.

Verification
REQ-027 1x1x1 job, A[0]=3, B[0]=-4 -> rd_en at cycle 1 (a_addr=0, b_addr=0); c_valid at cycle 3 with c_data=0xFFFFFFF4, c_addr=0; done at cycle 4.
REQ-028 M=N=K=2, A words {1,2,3,4}, B words {5,6,7,8}, c_ready high:
- first element reads a_addr 0,2 and b_addr 0,1;
- outputs (c_addr:c_data) 0:23, 1:31, 2:34, 3:46;
- done 1 cycle after the last handshake; 16 cycles from first rd_en to last handshake.
REQ-029 Backpressure: c_ready low 5 cycles during OUT -> c_valid, c_data and c_addr stable, rd_en=0 throughout; the job resumes on handshake.
REQ-030 Wrap: K=2, M=N=1, all operands -32768 -> c_data=0x80000000.
REQ-031 Boundary controls:
- cfg_k=0 start -> err and done pulse, no rd_en;
- start while busy -> ignored, running job unaffected;
- abort mid-ISSUE -> IDLE, no done.
REQ-032 rst_n asserted mid-ISSUE -> outputs zero immediately; a fresh 1x1x1 job afterwards matches REQ-027.
